// File: rtl/key_pkg.sv
// Shared constants, FSM state type and key-class helpers for the keypad entry path.
package key_pkg;

    localparam logic [4:0] KEY_NONE = 5'b10000;
    localparam logic [3:0] KEY_CLR  = 4'd10;
    localparam logic [3:0] KEY_BSP  = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        HELD
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_pressed(input logic [4:0] key);
        return ~key[4];
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Registers the scanner code and debounces it into one accept pulse per physical press.
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic [4:0] key_i,
    output logic       acc_pulse,
    output logic [3:0] acc_code
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    logic [4:0] key_q;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    state_e     state_q, state_d;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            key_q   <= KEY_NONE;
            cand_q  <= 4'd0;
            cnt_q   <= 4'd0;
            state_q <= IDLE;
        end else begin
            key_q   <= key_i;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        acc_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_pressed(key_q)) begin
                    cand_d  = key_q[3:0];
                    cnt_d   = 4'd1;
                    state_d = DEB;
                end
            end
            DEB: begin
                if (key_q == {1'b0, cand_q}) begin
                    if (cnt_q == CNT_LAST) begin
                        acc_pulse = 1'b1;
                        cnt_d     = 4'd0;
                        state_d   = HELD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            HELD: begin
                // Any pressed sample, even a different key, restarts the release count.
                if (is_pressed(key_q)) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    assign acc_code = cand_q;

endmodule

// File: rtl/key_entry_buffer.sv
// Debounced keypad front end feeding a right-aligned BCD digit entry buffer.
module key_entry_buffer
    import key_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DIGITS        = 4
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic [4:0]            Key,
    output logic                  KeyValid,
    output logic [3:0]            KeyCode,
    output logic [4*DIGITS-1:0]   Digits,
    output logic [2:0]            Count,
    output logic                  Overflow
);

    localparam int unsigned DW   = 4 * DIGITS;
    localparam logic [2:0]  FULL = 3'(DIGITS);

    logic          acc_pulse;
    logic [3:0]    acc_code;

    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [DW-1:0] digits_q, digits_d;
    logic [2:0]    count_q, count_d;
    logic          overflow_q, overflow_d;

    key_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .key_i     (Key),
        .acc_pulse (acc_pulse),
        .acc_code  (acc_code)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            digits_q    <= '0;
            count_q     <= 3'd0;
            overflow_q  <= 1'b0;
        end else begin
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    // The accept pulse is combinational from the debouncer, so the buffer and
    // KeyValid both land on the accepting edge.
    always_comb begin
        key_valid_d = acc_pulse;
        key_code_d  = key_code_q;
        digits_d    = digits_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        if (acc_pulse) begin
            key_code_d = acc_code;
            if (is_digit(acc_code)) begin
                if (count_q < FULL) begin
                    digits_d = (digits_q << 4) | DW'(acc_code);
                    count_d  = count_q + 3'd1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (acc_code == KEY_CLR) begin
                digits_d   = '0;
                count_d    = 3'd0;
                overflow_d = 1'b0;
            end else if (acc_code == KEY_BSP) begin
                if (count_q != 3'd0) begin
                    digits_d = digits_q >> 4;
                    count_d  = count_q - 3'd1;
                end
            end
        end
    end

    assign KeyValid = key_valid_q;
    assign KeyCode  = key_code_q;
    assign Digits   = digits_q;
    assign Count    = count_q;
    assign Overflow = overflow_q;

endmodule

// File: tb/tb_key_entry_buffer.sv
// Directed bench for key_entry_buffer with default parameters (4 stable samples, 4 digits).
module tb_key_entry_buffer;
    import key_pkg::*;

    logic        CLK;
    logic        RST_n;
    logic [4:0]  Key;
    logic        KeyValid;
    logic [3:0]  KeyCode;
    logic [15:0] Digits;
    logic [2:0]  Count;
    logic        Overflow;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    key_entry_buffer #(
        .STABLE_CYCLES (4),
        .DIGITS        (4)
    ) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .Key      (Key),
        .KeyValid (KeyValid),
        .KeyCode  (KeyCode),
        .Digits   (Digits),
        .Count    (Count),
        .Overflow (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic step_count(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            if (KeyValid) pulses++;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(KeyValid), 32'd0);
        check({tag, "_code"}, 32'(KeyCode), 32'd0);
        check({tag, "_digits"}, 32'(Digits), 32'd0);
        check({tag, "_count"}, 32'(Count), 32'd0);
        check({tag, "_ovf"}, 32'(Overflow), 32'd0);
    endtask

    // Clean press: pulse expected after the 5th edge, then release long enough to re-arm.
    task automatic press_release(input logic [3:0] code);
        Key = {1'b0, code};
        repeat (4) step();
        check("pre_pulse", 32'(KeyValid), 32'd0);
        step();
        check("pulse", 32'(KeyValid), 32'd1);
        check("pulse_code", 32'(KeyCode), 32'(code));
        Key = KEY_NONE;
        step();
        check("pulse_one_cycle", 32'(KeyValid), 32'd0);
        repeat (5) step();
    endtask

    task automatic check_buf(input string tag, input logic [15:0] d, input logic [2:0] c,
                             input logic o);
        check({tag, "_digits"}, 32'(Digits), 32'(d));
        check({tag, "_count"}, 32'(Count), 32'(c));
        check({tag, "_ovf"}, 32'(Overflow), 32'(o));
    endtask

    initial begin
        RST_n = 1'b0;
        Key   = KEY_NONE;
        step();
        step();
        check_outputs_zero("reset");
        RST_n = 1'b1;
        step();
        step();

        // Reset mid-debounce aborts, then the still-held key is re-debounced.
        Key = 5'd3;
        pulses = 0;
        step_count(3);
        check("mid_deb_no_pulse", 32'(pulses), 32'd0);
        RST_n = 1'b0;
        #2;
        check_outputs_zero("async_reset");
        step();
        RST_n = 1'b1;
        repeat (4) step();
        check("rearm_pre_pulse", 32'(KeyValid), 32'd0);
        step();
        check("rearm_pulse", 32'(KeyValid), 32'd1);
        check("rearm_code", 32'(KeyCode), 32'd3);
        check_buf("rearm", 16'h0003, 3'd1, 1'b0);
        Key = KEY_NONE;
        repeat (6) step();

        // Bounce: two-cycle pulses never reach four matching samples.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            Key = 5'd5;
            step_count(2);
            Key = KEY_NONE;
            step_count(2);
        end
        check("bounce_no_pulse", 32'(pulses), 32'd0);
        Key = 5'd5;
        step_count(4);
        check("bounce_pre_pulse", 32'(KeyValid), 32'd0);
        step_count(1);
        check("bounce_pulse", 32'(KeyValid), 32'd1);
        check("bounce_code", 32'(KeyCode), 32'd5);
        step_count(10);
        Key = KEY_NONE;
        step_count(6);
        check("bounce_single", 32'(pulses), 32'd1);
        check_buf("bounce", 16'h0035, 3'd2, 1'b0);

        press_release(KEY_CLR);
        check_buf("clr0", 16'h0000, 3'd0, 1'b0);

        // Entry up to full, then overflow.
        press_release(4'd1);
        press_release(4'd2);
        press_release(4'd3);
        press_release(4'd4);
        check_buf("entry", 16'h1234, 3'd4, 1'b0);
        press_release(4'd9);
        check_buf("overflow", 16'h1234, 3'd4, 1'b1);

        press_release(KEY_BSP);
        press_release(KEY_BSP);
        check_buf("bsp2", 16'h0012, 3'd2, 1'b1);
        press_release(KEY_CLR);
        check_buf("clr", 16'h0000, 3'd0, 1'b0);
        press_release(KEY_BSP);
        check_buf("bsp_empty", 16'h0000, 3'd0, 1'b0);
        check("bsp_empty_code", 32'(KeyCode), 32'd11);

        // Hold and roll-over: only the first key is ever accepted.
        pulses = 0;
        Key = 5'd7;
        step_count(50);
        Key = 5'd8;
        step_count(10);
        Key = KEY_NONE;
        step_count(8);
        check("rollover_pulses", 32'(pulses), 32'd1);
        check("rollover_code", 32'(KeyCode), 32'd7);
        check_buf("rollover", 16'h0007, 3'd1, 1'b0);

        press_release(4'd14);
        check_buf("ignored", 16'h0007, 3'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
